// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and port ids for the AXI4-Lite read arbiter.
package axi4_lite_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } t_arb_state;

  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/axi4_lite_read_arbiter_rr.sv
// Combinational two-way round-robin pick; a tie goes to the port opposite last_grant.
module rr_arbiter_2
  import axi4_lite_arb_pkg::*;
(
  input  logic req_0,
  input  logic req_1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_0 | req_1;
    grant_id    = REQ_IFETCH;
    if (req_0 && req_1) begin
      grant_id = ~last_grant;
    end else if (req_1) begin
      grant_id = REQ_DCACHE;
    end
  end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter/sequencer for the fetch and dcache ports in front of the AXI4-Lite read master.
//   state   | meaning
//   IDLE    | sample requests, latch grant id and address
//   ISSUE   | start pulse to master, ack to granted port
//   WAIT    | hold address until master done
//   RESPOND | done pulse to granted port, update round-robin pointer
module axi4_lite_read_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_0,
  input  logic                  i_req_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  output logic                  o_ack_0,
  output logic                  o_ack_1,
  output logic [DATA_WIDTH-1:0] o_data_0,
  output logic [DATA_WIDTH-1:0] o_data_1,
  output logic                  o_fault_0,
  output logic                  o_fault_1,
  output logic                  o_done_0,
  output logic                  o_done_1,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic                  o_m_start,
  input  logic [DATA_WIDTH-1:0] i_m_data,
  input  logic                  i_m_access_fault,
  input  logic                  i_m_done,
  output logic                  o_busy
);

  t_arb_state state_q;
  t_arb_state state_d;
  logic       grant_valid;
  logic       grant_id;
  logic       grant_q;
  logic       last_grant;
  logic       take_grant;
  logic       take_resp;

  rr_arbiter_2 u_rr (
    .req_0       (i_req_0),
    .req_1       (i_req_1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Requests only matter in IDLE; master done only matters in WAIT.
  assign take_grant = (state_q == IDLE) && grant_valid;
  assign take_resp  = (state_q == WAIT) && i_m_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (i_m_done) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is a flop; pulses are loaded one cycle ahead so they coincide with their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= REQ_IFETCH;
      last_grant <= REQ_DCACHE;
      o_m_addr   <= '0;
      o_m_start  <= 1'b0;
      o_ack_0    <= 1'b0;
      o_ack_1    <= 1'b0;
      o_done_0   <= 1'b0;
      o_done_1   <= 1'b0;
      o_data_0   <= '0;
      o_data_1   <= '0;
      o_fault_0  <= 1'b0;
      o_fault_1  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_m_start <= take_grant;
      o_ack_0   <= take_grant && (grant_id == REQ_IFETCH);
      o_ack_1   <= take_grant && (grant_id == REQ_DCACHE);
      o_done_0  <= take_resp && (grant_q == REQ_IFETCH);
      o_done_1  <= take_resp && (grant_q == REQ_DCACHE);
      o_busy    <= (state_d != IDLE);

      if (take_grant) begin
        grant_q  <= grant_id;
        o_m_addr <= (grant_id == REQ_DCACHE) ? i_addr_1 : i_addr_0;
      end

      if (take_resp && (grant_q == REQ_IFETCH)) begin
        o_data_0  <= i_m_data;
        o_fault_0 <= i_m_access_fault;
      end
      if (take_resp && (grant_q == REQ_DCACHE)) begin
        o_data_1  <= i_m_data;
        o_fault_1 <= i_m_access_fault;
      end

      if (state_q == RESPOND) begin
        last_grant <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Directed bench for axi4_lite_read_arbiter: transaction vector table plus hand-written corner sequences.
module tb_axi4_lite_read_arbiter;

  localparam int AW = 64;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_0, i_req_1;
  logic [AW-1:0] i_addr_0, i_addr_1;
  logic          o_ack_0, o_ack_1;
  logic [DW-1:0] o_data_0, o_data_1;
  logic          o_fault_0, o_fault_1;
  logic          o_done_0, o_done_1;
  logic [AW-1:0] o_m_addr;
  logic          o_m_start;
  logic [DW-1:0] i_m_data;
  logic          i_m_access_fault;
  logic          i_m_done;
  logic          o_busy;

  axi4_lite_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_0          (i_req_0),
    .i_req_1          (i_req_1),
    .i_addr_0         (i_addr_0),
    .i_addr_1         (i_addr_1),
    .o_ack_0          (o_ack_0),
    .o_ack_1          (o_ack_1),
    .o_data_0         (o_data_0),
    .o_data_1         (o_data_1),
    .o_fault_0        (o_fault_0),
    .o_fault_1        (o_fault_1),
    .o_done_0         (o_done_0),
    .o_done_1         (o_done_1),
    .o_m_addr         (o_m_addr),
    .o_m_start        (o_m_start),
    .i_m_data         (i_m_data),
    .i_m_access_fault (i_m_access_fault),
    .i_m_done         (i_m_done),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data;
    logic          fault;
    int            delay;
    logic          exp_port;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t          vecs[6];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] mdl_data[2];
  logic          mdl_fault[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_data0"},  o_data_0,  mdl_data[0]);
    chk({tag, "_data1"},  o_data_1,  mdl_data[1]);
    chk({tag, "_fault0"}, o_fault_0, mdl_fault[0]);
    chk({tag, "_fault1"}, o_fault_1, mdl_fault[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req_0 = 1'b0; i_req_1 = 1'b0;
    i_addr_0 = '0;  i_addr_1 = '0;
    i_m_data = '0;  i_m_access_fault = 1'b0; i_m_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      mdl_data[p]  = '0;
      mdl_fault[p] = 1'b0;
    end
  endtask

  // Returns after the IDLE cycle that follows RESPOND; requests still high remain pending.
  task automatic run_txn(input vec_t v);
    int n;
    i_addr_0 = v.addr0; i_addr_1 = v.addr1;
    i_req_0 = v.req0;   i_req_1 = v.req1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_m_start && n < 8);
    chk("start_latency", n, 1);
    if (!o_m_start) return;
    chk("ack_0", o_ack_0, v.exp_port == 1'b0);
    chk("ack_1", o_ack_1, v.exp_port == 1'b1);
    chk("m_addr", o_m_addr, v.exp_addr);
    if (v.exp_port == 1'b0) i_req_0 = 1'b0;
    else                    i_req_1 = 1'b0;
    repeat (v.delay) @(negedge clk);
    chk("busy_wait", o_busy, 1);
    chk("m_addr_hold", o_m_addr, v.exp_addr);
    chk("ack_gone", {o_ack_0, o_ack_1, o_m_start}, 0);
    i_m_data = v.data; i_m_access_fault = v.fault; i_m_done = 1'b1;
    @(negedge clk);
    i_m_done = 1'b0;
    mdl_data[v.exp_port]  = v.data;
    mdl_fault[v.exp_port] = v.fault;
    chk("done_0", o_done_0, v.exp_port == 1'b0);
    chk("done_1", o_done_1, v.exp_port == 1'b1);
    chk_regs("resp");
    @(negedge clk);
    chk("done_clear", {o_done_0, o_done_1}, 0);
    chk("busy_idle", o_busy, 0);
    chk_regs("held");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic exp_p;

    vecs[0] = '{1'b1, 1'b1, 64'h2000, 64'h3000, 32'h1111_0000, 1'b0, 1, 1'b0, 64'h2000};
    vecs[1] = '{1'b0, 1'b1, 64'h2000, 64'h3000, 32'h2222_0001, 1'b0, 2, 1'b1, 64'h3000};
    vecs[2] = '{1'b1, 1'b0, 64'h1000, 64'h3000, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 64'h1000};
    vecs[3] = '{1'b0, 1'b1, 64'h1000, 64'h4000, 32'h1234_5678, 1'b1, 1, 1'b1, 64'h4000};
    vecs[4] = '{1'b1, 1'b1, 64'h0000_00FF_FFFF_FFF0, 64'h8000_0000_0000_0004,
                32'hA5A5_A5A5, 1'b0, 5, 1'b0, 64'h0000_00FF_FFFF_FFF0};
    vecs[5] = '{1'b0, 1'b1, 64'h0000_00FF_FFFF_FFF0, 64'h8000_0000_0000_0004,
                32'h5A5A_5A5A, 1'b0, 1, 1'b1, 64'h8000_0000_0000_0004};

    do_reset();
    chk("rst_busy", o_busy, 0);
    chk("rst_pulses", {o_ack_0, o_ack_1, o_done_0, o_done_1, o_m_start}, 0);
    chk("rst_m_addr", o_m_addr, 0);
    chk_regs("rst");

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Stray done in IDLE
    i_m_data = 32'hFFFF_FFFF; i_m_access_fault = 1'b1; i_m_done = 1'b1;
    @(negedge clk);
    i_m_done = 1'b0;
    chk("stray_idle_done", {o_done_0, o_done_1}, 0);
    chk("stray_idle_busy", o_busy, 0);
    chk_regs("stray_idle");

    // Stray done in ISSUE, then a real completion
    i_addr_0 = 64'h5000; i_req_0 = 1'b1;
    @(negedge clk);
    chk("stray_issue_start", o_m_start, 1);
    chk("stray_issue_ack0", o_ack_0, 1);
    i_req_0 = 1'b0;
    i_m_data = 32'hFFFF_FFFF; i_m_access_fault = 1'b1; i_m_done = 1'b1;
    @(negedge clk);
    i_m_done = 1'b0;
    chk("stray_issue_done", {o_done_0, o_done_1}, 0);
    chk("stray_issue_busy", o_busy, 1);
    chk_regs("stray_issue");
    @(negedge clk);
    chk("stray_still_wait", {o_done_0, o_done_1, o_busy}, 3'b001);
    chk("stray_m_addr", o_m_addr, 64'h5000);
    i_m_data = 32'h0BAD_F00D; i_m_access_fault = 1'b0; i_m_done = 1'b1;
    @(negedge clk);
    i_m_done = 1'b0;
    mdl_data[0] = 32'h0BAD_F00D; mdl_fault[0] = 1'b0;
    chk("stray_real_done0", o_done_0, 1);
    chk_regs("stray_real");
    @(negedge clk);

    // Reset while in WAIT; last_grant is 0 here, so the tie goes to port 1 first
    i_addr_0 = 64'h6000; i_addr_1 = 64'h7000;
    i_req_0 = 1'b1; i_req_1 = 1'b1;
    @(negedge clk);
    chk("prerst_ack1", o_ack_1, 1);
    @(negedge clk);
    chk("prerst_busy", o_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      mdl_data[p] = '0; mdl_fault[p] = 1'b0;
    end
    chk("midrst_busy", o_busy, 0);
    chk("midrst_pulses", {o_ack_0, o_ack_1, o_done_0, o_done_1, o_m_start}, 0);
    chk("midrst_m_addr", o_m_addr, 0);
    chk_regs("midrst");
    @(negedge clk);
    chk("postrst_ack0", o_ack_0, 1);
    chk("postrst_ack1", o_ack_1, 0);
    chk("postrst_m_addr", o_m_addr, 64'h6000);
    i_req_0 = 1'b0;
    @(negedge clk);
    i_m_data = 32'h0000_600D; i_m_done = 1'b1;
    @(negedge clk);
    i_m_done = 1'b0; i_req_1 = 1'b0;
    mdl_data[0] = 32'h0000_600D;
    chk("postrst_done0", {o_done_0, o_done_1}, 2'b10);
    chk_regs("postrst");
    @(negedge clk);
    @(negedge clk);
    chk("postrst_idle", o_busy, 0);

    // Fairness: both requests held high across four transactions
    do_reset();
    i_addr_0 = 64'hA0; i_addr_1 = 64'hB0;
    i_req_0 = 1'b1; i_req_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_p = (k % 2 == 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_m_start && n < 8);
      chk("fair_start", o_m_start, 1);
      chk("fair_ack0", o_ack_0, exp_p == 1'b0);
      chk("fair_ack1", o_ack_1, exp_p == 1'b1);
      chk("fair_m_addr", o_m_addr, exp_p ? 64'hB0 : 64'hA0);
      @(negedge clk);
      i_m_data = 32'hF000_0000 | k; i_m_access_fault = 1'b0; i_m_done = 1'b1;
      @(negedge clk);
      i_m_done = 1'b0;
      mdl_data[exp_p] = 32'hF000_0000 | k;
      chk("fair_done", {o_done_1, o_done_0}, exp_p ? 2'b10 : 2'b01);
      chk_regs("fair");
    end
    i_req_0 = 1'b0; i_req_1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
